// File: rtl/otter_rvfi_checker.sv
// RVFI retirement-trace consumer: checks order/PC chain, x0, source-register coherence
// against a shadow regfile, memory mask sanity and PC alignment; latches the first violation.
module otter_rvfi_checker #(
    parameter int unsigned     XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_PC    = '0,
    parameter logic [63:0]     FIRST_ORDER = 64'd1,
    parameter bit              CHECK_RS    = 1'b1
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_clr,
    input  logic            i_rvfi_valid,
    input  logic [63:0]     i_rvfi_order,
    input  logic [31:0]     i_rvfi_insn,
    input  logic            i_rvfi_trap,
    input  logic            i_rvfi_intr,
    input  logic [XLEN-1:0] i_rvfi_pc_rdata,
    input  logic [XLEN-1:0] i_rvfi_pc_wdata,
    input  logic [4:0]      i_rvfi_rd_addr,
    input  logic [XLEN-1:0] i_rvfi_rd_wdata,
    input  logic [4:0]      i_rvfi_rs1_addr,
    input  logic [XLEN-1:0] i_rvfi_rs1_rdata,
    input  logic [4:0]      i_rvfi_rs2_addr,
    input  logic [XLEN-1:0] i_rvfi_rs2_rdata,
    input  logic [3:0]      i_rvfi_mem_rmask,
    input  logic [3:0]      i_rvfi_mem_wmask,
    output logic            o_err,
    output logic [3:0]      o_err_code,
    output logic [63:0]     o_err_order,
    output logic [XLEN-1:0] o_err_pc,
    output logic [31:0]     o_retired
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_ERR} state_t;

    state_t            state_q, state_d;
    logic [63:0]       exp_order_q;
    logic [XLEN-1:0]   exp_pc_q;
    logic [XLEN-1:0]   sh_q  [31:1];
    logic [31:1]       shv_q;
    logic              err_q;
    logic [3:0]        err_code_q;
    logic [63:0]       err_order_q;
    logic [XLEN-1:0]   err_pc_q;
    logic [31:0]       retired_q;

    logic              beat;
    logic              rs1_bad, rs2_bad;
    logic [3:0]        code;

    // Trace fields that carry no checkable invariant here.
    logic unused_fields;
    assign unused_fields = ^{i_rvfi_insn, i_rvfi_intr};

    assign beat = i_rvfi_valid && !i_clr && (state_q != S_ERR);

    // A source register never written since clear is unknown, so it is not checked.
    always_comb begin
        rs1_bad = 1'b0;
        rs2_bad = 1'b0;
        if (CHECK_RS) begin
            if (i_rvfi_rs1_addr == 5'd0) rs1_bad = (i_rvfi_rs1_rdata != '0);
            else rs1_bad = shv_q[i_rvfi_rs1_addr] && (i_rvfi_rs1_rdata != sh_q[i_rvfi_rs1_addr]);
            if (i_rvfi_rs2_addr == 5'd0) rs2_bad = (i_rvfi_rs2_rdata != '0);
            else rs2_bad = shv_q[i_rvfi_rs2_addr] && (i_rvfi_rs2_rdata != sh_q[i_rvfi_rs2_addr]);
        end
    end

    always_comb begin
        code = 4'd0;
        if      (i_rvfi_order != exp_order_q)                         code = 4'd1;
        else if (i_rvfi_pc_rdata != exp_pc_q)                         code = 4'd2;
        else if (i_rvfi_rd_addr == 5'd0 && i_rvfi_rd_wdata != '0)     code = 4'd3;
        else if (rs1_bad)                                             code = 4'd4;
        else if (rs2_bad)                                             code = 4'd5;
        else if (i_rvfi_mem_rmask != 4'd0 && i_rvfi_mem_wmask != 4'd0) code = 4'd6;
        else if (!i_rvfi_trap && i_rvfi_pc_wdata[1:0] != 2'd0)        code = 4'd7;
    end

    always_comb begin
        state_d = state_q;
        if (i_clr)                      state_d = S_IDLE;
        else if (beat && code != 4'd0)  state_d = S_ERR;
        else if (beat)                  state_d = S_RUN;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            exp_order_q <= FIRST_ORDER;
            exp_pc_q    <= RESET_PC;
            shv_q       <= '0;
            for (int i = 1; i < 32; i++) sh_q[i] <= '0;
            err_q       <= 1'b0;
            err_code_q  <= 4'd0;
            err_order_q <= 64'd0;
            err_pc_q    <= '0;
            retired_q   <= 32'd0;
        end else if (i_clr) begin
            exp_order_q <= FIRST_ORDER;
            exp_pc_q    <= RESET_PC;
            shv_q       <= '0;
            err_q       <= 1'b0;
            err_code_q  <= 4'd0;
            err_order_q <= 64'd0;
            err_pc_q    <= '0;
            retired_q   <= 32'd0;
        end else if (beat) begin
            if (code != 4'd0) begin
                err_q       <= 1'b1;
                err_code_q  <= code;
                err_order_q <= i_rvfi_order;
                err_pc_q    <= i_rvfi_pc_rdata;
            end else begin
                exp_order_q <= i_rvfi_order + 64'd1;
                exp_pc_q    <= i_rvfi_pc_wdata;
                if (retired_q != 32'hFFFF_FFFF) retired_q <= retired_q + 32'd1;
                if (i_rvfi_rd_addr != 5'd0) begin
                    sh_q[i_rvfi_rd_addr]  <= i_rvfi_rd_wdata;
                    shv_q[i_rvfi_rd_addr] <= 1'b1;
                end
            end
        end
    end

    assign o_err       = err_q;
    assign o_err_code  = err_code_q;
    assign o_err_order = err_order_q;
    assign o_err_pc    = err_pc_q;
    assign o_retired   = retired_q;

endmodule

// File: tb/tb_otter_rvfi_checker.sv
// Bench for otter_rvfi_checker: directed scenarios plus randomized trace against a behavioural model.
module tb_otter_rvfi_checker;

    typedef struct {
        logic        valid, clr, trap, intr;
        logic [63:0] order;
        logic [31:0] insn, pc, npc, rdw, rs1d, rs2d;
        logic [4:0]  rd, rs1, rs2;
        logic [3:0]  rmask, wmask;
    } beat_t;

    logic        clk = 1'b0, rst_n = 1'b0, clr = 1'b0;
    logic        valid = 1'b0, trap = 1'b0, intr = 1'b0;
    logic [63:0] order = '0;
    logic [31:0] insn = '0, pc = '0, npc = '0, rdw = '0, rs1d = '0, rs2d = '0;
    logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
    logic [3:0]  rmask = '0, wmask = '0;
    logic        o_err;
    logic [3:0]  o_err_code;
    logic [63:0] o_err_order;
    logic [31:0] o_err_pc, o_retired;

    int n_chk = 0, n_err = 0;

    // behavioural model state
    logic [63:0] m_exp_order;
    logic [31:0] m_exp_pc;
    logic [31:0] m_sh [32];
    bit   [31:0] m_shv;
    bit          m_err;
    logic [3:0]  m_code;
    logic [63:0] m_eorder;
    logic [31:0] m_epc, m_retired;

    always #5 clk = ~clk;

    otter_rvfi_checker dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr), .i_rvfi_valid(valid),
        .i_rvfi_order(order), .i_rvfi_insn(insn), .i_rvfi_trap(trap), .i_rvfi_intr(intr),
        .i_rvfi_pc_rdata(pc), .i_rvfi_pc_wdata(npc), .i_rvfi_rd_addr(rd), .i_rvfi_rd_wdata(rdw),
        .i_rvfi_rs1_addr(rs1), .i_rvfi_rs1_rdata(rs1d), .i_rvfi_rs2_addr(rs2), .i_rvfi_rs2_rdata(rs2d),
        .i_rvfi_mem_rmask(rmask), .i_rvfi_mem_wmask(wmask),
        .o_err(o_err), .o_err_code(o_err_code), .o_err_order(o_err_order),
        .o_err_pc(o_err_pc), .o_retired(o_retired)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic model_clear();
        m_exp_order = 64'd1;
        m_exp_pc    = 32'h0;
        m_shv       = '0;
        m_err       = 1'b0;
        m_code      = '0;
        m_eorder    = '0;
        m_epc       = '0;
        m_retired   = '0;
    endtask

    task automatic model_reset();
        model_clear();
        for (int i = 0; i < 32; i++) m_sh[i] = '0;
    endtask

    function automatic bit src_bad(input logic [4:0] a, input logic [31:0] d);
        if (a == 0) return d != 0;
        return m_shv[a] && d != m_sh[a];
    endfunction

    task automatic model_step(input beat_t b);
        bit bad [1:7];
        int code;
        if (b.clr) begin
            model_clear();
            return;
        end
        if (!b.valid || m_err) return;
        bad[1] = b.order != m_exp_order;
        bad[2] = b.pc != m_exp_pc;
        bad[3] = b.rd == 0 && b.rdw != 0;
        bad[4] = src_bad(b.rs1, b.rs1d);
        bad[5] = src_bad(b.rs2, b.rs2d);
        bad[6] = b.rmask != 0 && b.wmask != 0;
        bad[7] = !b.trap && b.npc[1:0] != 0;
        code = 0;
        for (int k = 7; k >= 1; k--) if (bad[k]) code = k;
        if (code != 0) begin
            m_err = 1'b1; m_code = 4'(code); m_eorder = b.order; m_epc = b.pc;
        end else begin
            m_exp_order = b.order + 64'd1;
            m_exp_pc    = b.npc;
            if (m_retired != 32'hFFFF_FFFF) m_retired = m_retired + 1;
            if (b.rd != 0) begin m_sh[b.rd] = b.rdw; m_shv[b.rd] = 1'b1; end
        end
    endtask

    function automatic beat_t mk(input logic [63:0] o, input logic [31:0] p, input logic [31:0] n);
        beat_t b;
        b.valid = 1'b1; b.clr = 1'b0; b.trap = 1'b0; b.intr = 1'b0;
        b.order = o; b.insn = 32'h13; b.pc = p; b.npc = n;
        b.rdw = '0; b.rs1d = '0; b.rs2d = '0; b.rd = '0; b.rs1 = '0; b.rs2 = '0;
        b.rmask = '0; b.wmask = '0;
        return b;
    endfunction

    function automatic beat_t idle_b();
        beat_t b = mk(64'd0, 32'd0, 32'd0);
        b.valid = 1'b0;
        return b;
    endfunction

    // Apply a beat, clock it in, advance the model, then park inputs just after the edge.
    task automatic send(input beat_t b);
        valid = b.valid; clr = b.clr; trap = b.trap; intr = b.intr; order = b.order;
        insn = b.insn; pc = b.pc; npc = b.npc; rd = b.rd; rdw = b.rdw;
        rs1 = b.rs1; rs1d = b.rs1d; rs2 = b.rs2; rs2d = b.rs2d; rmask = b.rmask; wmask = b.wmask;
        @(posedge clk);
        model_step(b);
        #1;
        valid = 1'b0; clr = 1'b0;
    endtask

    task automatic do_clr();
        beat_t b = idle_b();
        b.clr = 1'b1;
        send(b);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("err",       {63'd0, o_err}, {63'd0, m_err});
            chk("err_code",  {60'd0, o_err_code}, {60'd0, m_code});
            chk("err_order", o_err_order, m_eorder);
            chk("err_pc",    {32'd0, o_err_pc}, {32'd0, m_epc});
            chk("retired",   {32'd0, o_retired}, {32'd0, m_retired});
        end
    end

    initial begin
        beat_t b;
        int r;
        model_reset();
        #12;
        chk("reset_err", {63'd0, o_err}, 64'd0);
        chk("reset_retired", {32'd0, o_retired}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: clean chain with register forwarding
        b = mk(1, 32'h0, 32'h4); b.rd = 1; b.rdw = 5; send(b);
        b = mk(2, 32'h4, 32'h8); b.rd = 2; b.rdw = 10;
        b.rs1 = 1; b.rs1d = 5; b.rs2 = 1; b.rs2d = 5; send(b);
        b = mk(3, 32'h8, 32'hC); send(b);
        chk("t1_err", {63'd0, o_err}, 64'd0);
        chk("t1_retired", {32'd0, o_retired}, 64'd3);

        // 2: PC break
        do_clr();
        send(mk(1, 32'h0, 32'h4));
        send(mk(2, 32'h10, 32'h14));
        chk("t2_err", {63'd0, o_err}, 64'd1);
        chk("t2_code", {60'd0, o_err_code}, 64'd2);
        chk("t2_pc", {32'd0, o_err_pc}, 64'h10);
        chk("t2_order", o_err_order, 64'd2);

        // 3: stale rs1, then the same with a PC error taking priority
        do_clr();
        b = mk(1, 32'h0, 32'h4); b.rd = 3; b.rdw = 32'hAA; send(b);
        b = mk(2, 32'h4, 32'h8); b.rs1 = 3; b.rs1d = 32'hAB; send(b);
        chk("t3_code_rs1", {60'd0, o_err_code}, 64'd4);
        do_clr();
        b = mk(1, 32'h0, 32'h4); b.rd = 3; b.rdw = 32'hAA; send(b);
        b = mk(2, 32'h20, 32'h24); b.rs1 = 3; b.rs1d = 32'hAB; send(b);
        chk("t3_code_pc", {60'd0, o_err_code}, 64'd2);

        // 4: x0 write, conflicting memory masks
        do_clr();
        b = mk(1, 32'h0, 32'h4); b.rdw = 7; send(b);
        chk("t4_code_x0", {60'd0, o_err_code}, 64'd3);
        do_clr();
        b = mk(1, 32'h0, 32'h4); b.rmask = 4'hF; b.wmask = 4'h1; send(b);
        chk("t4_code_mem", {60'd0, o_err_code}, 64'd6);

        // 5: latched error is sticky, clear recovers
        b = mk(5, 32'h40, 32'h41); b.rdw = 3; send(b);
        chk("t5_code_held", {60'd0, o_err_code}, 64'd6);
        chk("t5_order_held", o_err_order, 64'd1);
        do_clr();
        chk("t5_cleared", {63'd0, o_err}, 64'd0);
        send(mk(1, 32'h0, 32'h4));
        chk("t5_retired", {32'd0, o_retired}, 64'd1);

        // clear wins over a simultaneous beat
        b = mk(2, 32'h4, 32'h8); b.clr = 1'b1; send(b);
        send(mk(1, 32'h0, 32'h4));
        chk("clr_beat_retired", {32'd0, o_retired}, 64'd1);
        chk("clr_beat_err", {63'd0, o_err}, 64'd0);

        // 6: async reset mid-cycle, shadow valids forgotten
        b = mk(2, 32'h4, 32'h8); b.rd = 5; b.rdw = 9; send(b);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_retired_async", {32'd0, o_retired}, 64'd0);
        chk("t6_err_async", {63'd0, o_err}, 64'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        b = mk(1, 32'h0, 32'h4); b.rs1 = 5; b.rs1d = 32'h123; send(b);
        chk("t6_shv_cleared", {63'd0, o_err}, 64'd0);

        // randomized trace
        for (int i = 0; i < 3000; i++) begin
            b = idle_b();
            r = $urandom_range(99);
            if (m_err && r < 30) b.clr = 1'b1;
            else if (r < 4) begin b.clr = 1'b1; b.valid = 1'($urandom_range(1)); end
            else if (r >= 14) begin
                b = mk(m_exp_order, m_exp_pc, m_exp_pc + 32'(4 * $urandom_range(4)));
                b.trap = ($urandom_range(19) == 0);
                if (b.trap) b.npc = $urandom;
                b.rd  = 5'($urandom_range(31));
                b.rdw = (b.rd == 0) ? 32'd0 : $urandom;
                b.rs1 = 5'($urandom_range(31));
                b.rs1d = (b.rs1 == 0) ? 32'd0 : (m_shv[b.rs1] ? m_sh[b.rs1] : $urandom);
                b.rs2 = 5'($urandom_range(31));
                b.rs2d = (b.rs2 == 0) ? 32'd0 : (m_shv[b.rs2] ? m_sh[b.rs2] : $urandom);
                case ($urandom_range(2))
                    1: b.rmask = 4'($urandom_range(15));
                    2: b.wmask = 4'($urandom_range(15));
                    default: ;
                endcase
                if ($urandom_range(9) == 0) begin
                    case ($urandom_range(6))
                        0: b.order = b.order + 64'($urandom_range(3) + 1);
                        1: b.pc = b.pc + 32'h4;
                        2: begin b.rd = 0; b.rdw = $urandom | 32'h1; end
                        3: b.rs1d = b.rs1d ^ 32'h1;
                        4: b.rs2d = b.rs2d ^ 32'h1;
                        5: begin b.rmask = 4'h1; b.wmask = 4'h2; end
                        default: begin b.trap = 1'b0; b.npc = b.npc | 32'h1; end
                    endcase
                end
            end
            send(b);
        end

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
